ca_update_scheduler: RTL and testbench

CA_UPDATE_SCHEDULER -- requirements
Module: ca_update_scheduler

---
 rtl/ca_update_scheduler.sv | 175 +++++++++++++++++
 tb/tb_ca_update_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_update_scheduler.sv
// Schedules colour-adaptation matrix updates: periodic/forced ALS read, hysteresis
// check, shadow-matrix calculation, pixel-pipe drain and atomic coefficient commit.
module ca_update_scheduler #(
  parameter int PERIOD_CYCLES  = 1000000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CCT_HYST       = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        als_req,
  input  logic        als_done,
  input  logic        als_error,
  input  logic [15:0] als_cct,
  output logic        calc_req,
  output logic [15:0] calc_cct,
  input  logic        calc_done,
  input  logic        pipe_empty,
  output logic        coef_commit,
  input  logic        force_update,
  input  logic        up_valid,
  output logic        up_ready,
  output logic        dn_valid,
  input  logic        dn_ready,
  output logic [15:0] active_cct,
  output logic [7:0]  err_count,
  output logic [7:0]  status
);

  localparam int TW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ALS_REQ   = 3'd1,
    S_ALS_WAIT  = 3'd2,
    S_CALC_REQ  = 3'd3,
    S_CALC_WAIT = 3'd4,
    S_DRAIN     = 3'd5,
    S_COMMIT    = 3'd6
  } state_t;

  state_t      r_state;
  logic [TW-1:0] r_timer;
  logic [WW-1:0] r_wait;
  logic [7:0]  r_err;
  logic [15:0] r_active;
  logic        r_active_valid;
  logic [15:0] r_new;
  logic [15:0] r_calc_cct;
  logic        r_force_pend;
  logic        r_force_d;
  logic        r_forced;
  logic        r_als_req;
  logic        r_calc_req;
  logic        r_commit;

  logic               w_force_edge;
  logic signed [16:0] w_diff;
  logic [16:0]        w_abs;
  logic               w_need_calc;
  logic               w_wait_to;
  logic [7:0]         w_err_next;
  logic               w_gate_open;

  assign w_force_edge = force_update & ~r_force_d;
  assign w_diff       = $signed({1'b0, als_cct}) - $signed({1'b0, r_active});
  assign w_abs        = w_diff[16] ? $unsigned(-w_diff) : $unsigned(w_diff);
  // A forced update, or the very first one, bypasses the hysteresis window.
  assign w_need_calc  = ~r_active_valid | r_forced | (w_abs >= 17'(CCT_HYST));
  assign w_wait_to    = (r_wait == WW'(TIMEOUT_CYCLES));
  assign w_err_next   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
  assign w_gate_open  = (r_state != S_DRAIN) && (r_state != S_COMMIT);

  // Gating rst_n in keeps the pixel handshake closed for the whole reset window.
  assign dn_valid    = up_valid & w_gate_open & rst_n;
  assign up_ready    = dn_ready & w_gate_open & rst_n;

  assign als_req     = r_als_req;
  assign calc_req    = r_calc_req;
  assign calc_cct    = r_calc_cct;
  assign coef_commit = r_commit;
  assign active_cct  = r_active;
  assign err_count   = r_err;
  assign status      = {(r_err != 8'd0), r_active_valid, w_gate_open, 2'b00, r_state};

  // NOTE: all state uses non-blocking assignments so every branch reads the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_wait         <= '0;
      r_err          <= '0;
      r_active       <= '0;
      r_active_valid <= 1'b0;
      r_new          <= '0;
      r_calc_cct     <= '0;
      r_force_pend   <= 1'b0;
      r_forced       <= 1'b0;
      r_als_req      <= 1'b0;
      r_calc_req     <= 1'b0;
      r_commit       <= 1'b0;
      // NOTE: tracks the live level in reset so a switch held high is not an edge.
      r_force_d      <= force_update;
    end else begin
      r_force_d  <= force_update;
      r_als_req  <= 1'b0;
      r_calc_req <= 1'b0;
      r_commit   <= 1'b0;
      if (w_force_edge) r_force_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if ((r_timer == TW'(PERIOD_CYCLES - 1)) || r_force_pend) begin
            r_state      <= S_ALS_REQ;
            r_timer      <= '0;
            r_als_req    <= 1'b1;
            r_forced     <= r_force_pend;
            r_force_pend <= w_force_edge;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_ALS_REQ: begin
          r_state <= S_ALS_WAIT;
          r_wait  <= '0;
        end
        S_ALS_WAIT: begin
          if (als_error || w_wait_to) begin
            r_err   <= w_err_next;
            r_state <= S_IDLE;
          end else if (als_done) begin
            r_new <= als_cct;
            if (w_need_calc) begin
              r_state    <= S_CALC_REQ;
              r_calc_req <= 1'b1;
              r_calc_cct <= als_cct;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_CALC_REQ: begin
          r_state <= S_CALC_WAIT;
          r_wait  <= '0;
        end
        S_CALC_WAIT: begin
          if (calc_done) begin
            r_state <= S_DRAIN;
          end else if (w_wait_to) begin
            r_err   <= w_err_next;
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_DRAIN: begin
          if (pipe_empty) begin
            r_state  <= S_COMMIT;
            r_commit <= 1'b1;
          end
        end
        S_COMMIT: begin
          r_active       <= r_new;
          r_active_valid <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_update_scheduler.sv
// Self-checking bench for ca_update_scheduler: directed vectors, hand sequences
// for the multi-cycle corners, and randomized episodes against a transaction model.
module tb_ca_update_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        als_req, als_done, als_error;
  logic [15:0] als_cct;
  logic        calc_req, calc_done;
  logic [15:0] calc_cct;
  logic        pipe_empty, coef_commit, force_update;
  logic        up_valid, up_ready, dn_valid, dn_ready;
  logic [15:0] active_cct;
  logic [7:0]  err_count, status;

  ca_update_scheduler #(
    .PERIOD_CYCLES (100),
    .TIMEOUT_CYCLES(50),
    .CCT_HYST      (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .als_req     (als_req),
    .als_done    (als_done),
    .als_error   (als_error),
    .als_cct     (als_cct),
    .calc_req    (calc_req),
    .calc_cct    (calc_cct),
    .calc_done   (calc_done),
    .pipe_empty  (pipe_empty),
    .coef_commit (coef_commit),
    .force_update(force_update),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready),
    .active_cct  (active_cct),
    .err_count   (err_count),
    .status      (status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Event monitor, sampled on the falling edge away from the active edge.
  int n_commit = 0, n_calc = 0, n_als = 0;
  bit mon_en = 1'b0;
  int n_mon, n_in, n_out, n_closed_up, n_closed_dn;
  always @(negedge clk) begin
    if (coef_commit) n_commit++;
    if (calc_req)    n_calc++;
    if (als_req)     n_als++;
    if (mon_en) begin
      n_mon++;
      if (up_valid && up_ready)  n_in++;
      if (dn_valid && dn_ready)  n_out++;
      if (up_valid && !up_ready) n_closed_up++;
      if (up_valid && !dn_valid) n_closed_dn++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the committed CCT, whether it is valid, and the error count.
  int m_active = 0;
  bit m_valid  = 1'b0;
  int m_err    = 0;

  function automatic bit model_wants(input int cct, input bit forced);
    int d;
    d = cct - m_active;
    if (d < 0) d = -d;
    return !m_valid || forced || (d >= 100);
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One update episode seen from the ALS/calculator side.
  task automatic run_update(input logic [15:0] cct, input int als_dly, input bit do_done,
                            input bit do_err, input bit do_calc_done, input int calc_dly,
                            input bit force_mid, output bit saw_calc, output bit saw_commit,
                            output logic [15:0] seen_cct, output int wait_cyc,
                            output int commit_lat);
    saw_calc   = 1'b0;
    saw_commit = 1'b0;
    seen_cct   = '0;
    commit_lat = -1;
    wait_cyc   = 0;
    while (!als_req && wait_cyc < 300) begin
      tick();
      wait_cyc++;
    end
    check("als_req_seen", 32'(als_req), 32'd1);
    if (!als_req) return;
    repeat (als_dly) tick();
    als_cct   = cct;
    als_done  = do_done;
    als_error = do_err;
    tick();
    als_done  = 1'b0;
    als_error = 1'b0;
    if (!do_done && !do_err) begin
      repeat (60) tick();
      return;
    end
    saw_calc = calc_req;
    seen_cct = calc_cct;
    if (!saw_calc) begin
      tick();
      return;
    end
    tick();
    if (force_mid) force_update = 1'b1;
    repeat (calc_dly - 1) tick();
    if (!do_calc_done) begin
      repeat (60) tick();
      force_update = 1'b0;
      return;
    end
    calc_done = 1'b1;
    tick();
    calc_done    = 1'b0;
    force_update = 1'b0;
    commit_lat   = 0;
    while (!coef_commit && commit_lat < 100) begin
      tick();
      commit_lat++;
    end
    saw_commit = coef_commit;
    tick();
  endtask

  typedef struct {
    logic [15:0] cct;
    bit          exp_calc;
    logic [15:0] exp_active;
  } vec_t;

  vec_t vecs[10];

  bit          sc, scm;
  logic [15:0] scct;
  int          wc, cl, c0, q0, a0, n, kind, v;
  bit          e_calc, e_err, als_to, calc_to, d_done, d_err;
  logic [15:0] cct;

  initial begin
    vecs[0] = '{16'd5050,  1'b0, 16'd5000};
    vecs[1] = '{16'd5100,  1'b1, 16'd5100};
    vecs[2] = '{16'd5001,  1'b0, 16'd5100};
    vecs[3] = '{16'd5000,  1'b1, 16'd5000};
    vecs[4] = '{16'd0,     1'b1, 16'd0};
    vecs[5] = '{16'd99,    1'b0, 16'd0};
    vecs[6] = '{16'd100,   1'b1, 16'd100};
    vecs[7] = '{16'd65535, 1'b1, 16'd65535};
    vecs[8] = '{16'd65436, 1'b0, 16'd65535};
    vecs[9] = '{16'd65435, 1'b1, 16'd65435};

    rst_n = 1'b0; als_done = 1'b0; als_error = 1'b0; als_cct = '0;
    calc_done = 1'b0; pipe_empty = 1'b1; force_update = 1'b1;
    up_valid = 1'b1; dn_ready = 1'b1;
    repeat (3) tick();

    // Reset state, with the force switch held high and a pixel offered.
    check("rst_status",     32'(status),     32'h20);
    check("rst_dn_valid",   32'(dn_valid),   32'd0);
    check("rst_up_ready",   32'(up_ready),   32'd0);
    check("rst_als_req",    32'(als_req),    32'd0);
    check("rst_commit",     32'(coef_commit), 32'd0);
    check("rst_active_cct", 32'(active_cct), 32'd0);
    check("rst_err_count",  32'(err_count),  32'd0);
    check("rst_calc_cct",   32'(calc_cct),   32'd0);

    // First automatic update: request exactly 100 cycles after release.
    rst_n = 1'b1;
    n = 0;
    while (!als_req && n < 300) begin
      tick();
      n++;
    end
    check("first_als_req_cycle", 32'(n), 32'd100);
    force_update = 1'b0;
    c0 = n_commit; q0 = n_calc;
    run_update(16'd5000, 10, 1'b1, 1'b0, 1'b1, 20, 1'b0, sc, scm, scct, wc, cl);
    check("first_calc_req",   32'(sc),   32'd1);
    check("first_calc_cct",   32'(scct), 32'd5000);
    check("first_commit",     32'(scm),  32'd1);
    check("first_commit_lat", 32'(cl),   32'd1);
    check("first_commit_cnt", 32'(n_commit - c0), 32'd1);
    check("first_calc_cnt",   32'(n_calc - q0),   32'd1);
    check("first_active_cct", 32'(active_cct),    32'd5000);
    check("first_status6",    32'(status[6]),     32'd1);
    check("first_gate_back",  32'(status[5]),     32'd1);

    // Hysteresis vectors around the +/-100 K window and the 16-bit extremes.
    for (int i = 0; i < 10; i++) begin
      c0 = n_commit; q0 = n_calc;
      run_update(vecs[i].cct, 1 + i, 1'b1, 1'b0, 1'b1, 3, 1'b0, sc, scm, scct, wc, cl);
      check($sformatf("vec%0d_calc", i),   32'(n_calc - q0),   32'(vecs[i].exp_calc));
      check($sformatf("vec%0d_commit", i), 32'(n_commit - c0), 32'(vecs[i].exp_calc));
      check($sformatf("vec%0d_active", i), 32'(active_cct),    32'(vecs[i].exp_active));
      check($sformatf("vec%0d_idle", i),   32'(status[2:0]),   32'd0);
      if (vecs[i].exp_calc) begin
        check($sformatf("vec%0d_calc_cct", i), 32'(scct), 32'(vecs[i].cct));
        check($sformatf("vec%0d_latency", i),  32'(cl),   32'd1);
      end
    end
    m_active = 65435; m_valid = 1'b1; m_err = 0;

    // Randomized episodes against the model.
    for (int i = 0; i < 25; i++) begin
      kind    = $urandom_range(0, 9);
      als_to  = (kind == 1);
      d_err   = (kind == 0) || (kind == 3);
      d_done  = (kind != 0) && (kind != 1);
      calc_to = (kind == 2);
      if ($urandom_range(0, 1) == 1) begin
        v = m_active + int'($urandom_range(0, 300)) - 150;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
      end else begin
        v = int'($urandom_range(0, 65535));
      end
      cct = 16'(v);
      e_calc = 1'b0;
      e_err  = 1'b0;
      if (als_to || d_err) e_err = 1'b1;
      else begin
        e_calc = model_wants(v, 1'b0);
        if (e_calc && calc_to) e_err = 1'b1;
      end
      c0 = n_commit; q0 = n_calc;
      run_update(cct, $urandom_range(1, 12), d_done, d_err, !calc_to,
                 $urandom_range(2, 12), 1'b0, sc, scm, scct, wc, cl);
      if (e_err) m_err = sat_inc(m_err);
      if (e_calc && !calc_to) begin
        m_active = v;
        m_valid  = 1'b1;
      end
      check($sformatf("rnd%0d_calc", i),   32'(n_calc - q0), 32'(e_calc));
      check($sformatf("rnd%0d_commit", i), 32'(n_commit - c0), 32'(e_calc && !calc_to));
      check($sformatf("rnd%0d_active", i), 32'(active_cct), 32'(m_active));
      check($sformatf("rnd%0d_err", i),    32'(err_count),  32'(m_err));
      check($sformatf("rnd%0d_idle", i),   32'(status[2:0]), 32'd0);
      if (e_calc) check($sformatf("rnd%0d_calc_cct", i), 32'(scct), 32'(v));
    end

    // ALS timeout: no done for the whole window.
    c0 = n_commit;
    run_update(16'd1234, 2, 1'b0, 1'b0, 1'b1, 2, 1'b0, sc, scm, scct, wc, cl);
    m_err = sat_inc(m_err);
    check("als_timeout_err",    32'(err_count),     32'(m_err));
    check("als_timeout_commit", 32'(n_commit - c0), 32'd0);
    check("als_timeout_idle",   32'(status[2:0]),   32'd0);
    check("err_flag",           32'(status[7]),     32'd1);

    // Same-cycle done and error: the error wins.
    c0 = n_commit; q0 = n_calc;
    run_update(16'(m_active ^ 16'h8000), 4, 1'b1, 1'b1, 1'b1, 2, 1'b0, sc, scm, scct, wc, cl);
    m_err = sat_inc(m_err);
    check("done_err_calc",   32'(n_calc - q0),   32'd0);
    check("done_err_commit", 32'(n_commit - c0), 32'd0);
    check("done_err_count",  32'(err_count),     32'(m_err));

    // Force edge during CALC_WAIT, then a reading equal to the new active CCT.
    cct = 16'((m_active + 1000) % 65536);
    c0 = n_commit;
    run_update(cct, 3, 1'b1, 1'b0, 1'b1, 5, 1'b1, sc, scm, scct, wc, cl);
    m_active = int'(cct);
    check("force_first_commit", 32'(scm),        32'd1);
    check("force_first_active", 32'(active_cct), 32'(m_active));
    q0 = n_calc;
    run_update(cct, 2, 1'b1, 1'b0, 1'b1, 3, 1'b0, sc, scm, scct, wc, cl);
    check("force_restart_wait", 32'(wc),         32'd1);
    check("force_calc",         32'(n_calc - q0), 32'(model_wants(int'(cct), 1'b1)));
    check("force_commit_cnt",   32'(n_commit - c0), 32'd2);
    check("force_active",       32'(active_cct), 32'(m_active));

    // Drain with a busy pipe for 7 cycles starting at the calc_done cycle.
    n = 0;
    while (!als_req && n < 300) begin
      tick();
      n++;
    end
    check("drain_als_req", 32'(als_req), 32'd1);
    tick(); tick();
    cct = 16'((m_active + 3000) % 65536);
    als_cct = cct; als_done = 1'b1;
    tick();
    als_done = 1'b0;
    check("drain_calc_req", 32'(calc_req), 32'd1);
    n_mon = 0; n_in = 0; n_out = 0; n_closed_up = 0; n_closed_dn = 0;
    mon_en = 1'b1;
    repeat (3) tick();
    calc_done = 1'b1; pipe_empty = 1'b0;
    tick();
    calc_done = 1'b0;
    repeat (6) tick();
    pipe_empty = 1'b1;
    n = 0;
    while (!coef_commit && n < 50) begin
      tick();
      n++;
    end
    check("drain_commit_lat", 32'(n), 32'd1);
    tick(); tick();
    mon_en = 1'b0;
    m_active = int'(cct);
    check("drain_closed_up", 32'(n_closed_up), 32'd8);
    check("drain_closed_dn", 32'(n_closed_dn), 32'd8);
    check("drain_in_count",  32'(n_in),        32'(n_mon - 8));
    check("drain_in_eq_out", 32'(n_out),       32'(n_in));
    check("drain_active",    32'(active_cct),  32'(m_active));

    // Reset in the middle of CALC_WAIT abandons the update.
    n = 0;
    while (!als_req && n < 300) begin
      tick();
      n++;
    end
    tick(); tick();
    als_cct = 16'((m_active + 5000) % 65536); als_done = 1'b1;
    tick();
    als_done = 1'b0;
    tick(); tick();
    force_update = 1'b1;
    rst_n = 1'b0;
    c0 = n_commit;
    tick(); tick();
    check("midrst_active", 32'(active_cct), 32'd0);
    check("midrst_err",    32'(err_count),  32'd0);
    check("midrst_status", 32'(status),     32'h20);
    rst_n = 1'b1;
    a0 = n_als;
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    repeat (5) tick();
    check("midrst_no_commit", 32'(n_commit - c0), 32'd0);
    check("midrst_no_edge",   32'(n_als - a0),    32'd0);
    check("midrst_idle",      32'(status[2:0]),   32'd0);
    force_update = 1'b0;
    tick();

    // 260 consecutive ALS failures: the counter saturates at 255.
    c0 = n_commit;
    for (int i = 0; i < 260; i++) begin
      force_update = 1'b1;
      tick();
      force_update = 1'b0;
      n = 0;
      while (!als_req && n < 10) begin
        tick();
        n++;
      end
      tick();
      als_error = 1'b1;
      tick();
      als_error = 1'b0;
      if (i == 253) check("sat_err_254", 32'(err_count), 32'd254);
      if (i == 254) check("sat_err_255", 32'(err_count), 32'd255);
    end
    check("sat_err_final", 32'(err_count),     32'd255);
    check("sat_no_commit", 32'(n_commit - c0), 32'd0);
    check("sat_active",    32'(active_cct),    32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
